// File: rtl/cdc_pkg.sv
// Shared CDC helpers for the Gray pointer link: Gray/binary conversion and bit counting.
// Both the binary->Gray encoder side and the Gray->binary decoder side use this package.
package cdc_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int CDC_MAX_WIDTH   = 64;

  typedef logic [CDC_MAX_WIDTH-1:0] cdc_word_t;

  // Bits at or above 'width' are treated as absent, so narrower buses can be zero-extended into a cdc_word_t.
  function automatic cdc_word_t gray2bin(input cdc_word_t g, input int width);
    cdc_word_t b;
    logic      acc;
    b   = '0;
    acc = 1'b0;
    for (int i = CDC_MAX_WIDTH - 1; i >= 0; i--) begin
      if (i < width) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

  function automatic cdc_word_t bin2gray(input cdc_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input cdc_word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < CDC_MAX_WIDTH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/g2b_sync_decoder_if.sv
// Bus bundle between a Gray-pointer consumer and the g2b_sync_decoder.
// master drives the foreign Gray code and error clear; slave is the decoder.
interface g2b_sync_decoder_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] gray_in;
  logic             err_clr;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             updated;
  logic [WIDTH-1:0] delta;
  logic             gray_err;
  logic             err_sticky;

  modport master (
    output gray_in,
    output err_clr,
    input  bin_out,
    input  bin_valid,
    input  updated,
    input  delta,
    input  gray_err,
    input  err_sticky
  );

  modport slave (
    input  gray_in,
    input  err_clr,
    output bin_out,
    output bin_valid,
    output updated,
    output delta,
    output gray_err,
    output err_sticky
  );

endinterface

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchroniser for a bus whose bits change one at a time (Gray code).
// Every stage resets asynchronously to zero.
module cdc_sync_bus #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/g2b_sync_decoder.sv
// Receive side of a Gray-coded pointer crossing: synchronise, decode to binary, flag updates and step size.
// Define GRAY_ERR_CHK_EN to add the multi-bit Gray step checker (gray_err / err_sticky).
module g2b_sync_decoder
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  g2b_sync_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] VALID_AT = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SYNC_STAGES + 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("g2b_sync_decoder: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end
  if (WIDTH > CDC_MAX_WIDTH) begin : g_bad_width
    $error("g2b_sync_decoder: WIDTH exceeds %0d", CDC_MAX_WIDTH);
  end

  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] delta_q;
  logic             upd_q;
  logic             valid_q;
  logic [CNT_W-1:0] warm_cnt;
  logic             changed;

  cdc_sync_bus #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (gray_s)
  );

  assign dec     = WIDTH'(gray2bin(cdc_word_t'(gray_s), WIDTH));
  assign changed = valid_q && (dec != bin_q);

  // bin_valid goes high once the chain has been fully refilled since reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm_cnt <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (warm_cnt != CNT_SAT) warm_cnt <= warm_cnt + 1'b1;
      if (warm_cnt >= VALID_AT) valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      delta_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      bin_q <= dec;
      upd_q <= changed;
      if (changed) delta_q <= dec - bin_q;
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.updated   = upd_q;
  assign bus.delta     = delta_q;

`ifdef GRAY_ERR_CHK_EN
  logic [WIDTH-1:0] gray_prev;
  logic             illegal_step;
  logic             err_q;
  logic             sticky_q;

  // gray_prev is the Gray word behind bin_out, so the check lines up with the updated pulse.
  assign illegal_step = valid_q && (popcount(cdc_word_t'(gray_s ^ gray_prev)) > 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_prev <= '0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      gray_prev <= gray_s;
      err_q     <= illegal_step;
      if (illegal_step)     sticky_q <= 1'b1;
      else if (bus.err_clr) sticky_q <= 1'b0;
    end
  end

  assign bus.gray_err   = err_q;
  assign bus.err_sticky = sticky_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.gray_err   = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

endmodule
